ascii_bcd_counter: RTL and testbench

//   Parametrised N-digit decimal counter operating directly on ASCII digit bytes.

---
 rtl/ascii_bcd_counter.sv | 150 +++++++++++++++
 tb/tb_ascii_bcd_counter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_bcd_counter.sv
// ascii_bcd_counter
//   N-digit decimal counter that works directly on ASCII digit bytes. A preset
//   is loaded from ascii_in, then the count steps up or down by one on every
//   enabled cycle, with decimal carry/borrow rippling across all digits in a
//   single cycle. At the terminal value (all '0' counting down, all '9'
//   counting up) it either stops and raises done, or wraps to the opposite
//   extreme and pulses wrapped for one cycle.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   load      in   sample ascii_in as the new count (wins over enable)
//   ascii_in  in   8*DIGITS preset, most significant digit in the top byte
//   enable    in   advance the count by one this cycle
//   up        in   1 = increment, 0 = decrement
//   wrap      in   1 = wrap at terminal, 0 = stop at terminal
//   counter   out  8*DIGITS current count, every byte in 8'h30..8'h39
//   done      out  level, terminal reached in stop mode
//   wrapped   out  one-cycle pulse on a wrap-around step
//   error     out  level, last load contained a non-digit byte

module ascii_bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [8*DIGITS-1:0]   ascii_in,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  wrap,
  output logic [8*DIGITS-1:0]   counter,
  output logic                  done,
  output logic                  wrapped,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [8*DIGITS-1:0] terminal;
  logic [8*DIGITS-1:0] step_value;
  logic                load_valid;
  logic                at_terminal;
  logic                carry;
  logic [3:0]          digit;
  logic [3:0]          next_digit;
  logic [7:0]          in_byte;

  // The terminal value depends on the direction currently requested.
  assign terminal    = up ? {DIGITS{8'h39}} : {DIGITS{8'h30}};
  assign at_terminal = (counter == terminal);

  // Preset is only accepted when every byte is an ASCII decimal digit.
  always_comb begin
    load_valid = 1'b1;
    in_byte    = 8'h00;
    for (int i = 0; i < DIGITS; i++) begin
      in_byte = ascii_in[8*i +: 8];
      if (in_byte < 8'h30 || in_byte > 8'h39) begin
        load_valid = 1'b0;
      end
    end
  end

  // One-step increment/decrement with the carry (or borrow) rippling from the
  // least significant digit upward. Because counter bytes are always valid
  // digits, the low nibble is the BCD digit value. Stepping past the extreme
  // naturally produces the opposite extreme, which is exactly the wrap value.
  always_comb begin
    step_value = counter;
    carry      = 1'b1;
    digit      = 4'd0;
    next_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit      = counter[8*i +: 4];
      next_digit = digit;
      if (carry) begin
        if (up) begin
          if (digit == 4'd9) begin
            next_digit = 4'd0;
          end else begin
            next_digit = digit + 4'd1;
            carry      = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            next_digit = 4'd9;
          end else begin
            next_digit = digit - 4'd1;
            carry      = 1'b0;
          end
        end
      end
      step_value[8*i +: 8] = {4'h3, next_digit};
    end
  end

  // Control FSM with registered outputs. Load is handled first so it always
  // beats enable. If the count already sits on the terminal in stop mode
  // (e.g. after the direction changed) it stops there instead of stepping
  // past it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= {DIGITS{8'h30}};
      done    <= 1'b0;
      wrapped <= 1'b0;
      error   <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      if (load) begin
        if (load_valid) begin
          counter <= ascii_in;
          error   <= 1'b0;
          if (ascii_in == terminal && !wrap) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RUN;
            done  <= 1'b0;
          end
        end else begin
          error <= 1'b1;
          done  <= 1'b0;
          state <= IDLE;
        end
      end else if (enable && state == RUN) begin
        if (at_terminal && !wrap) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          counter <= step_value;
          if (at_terminal) begin
            wrapped <= 1'b1;
          end else if (step_value == terminal && !wrap) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ascii_bcd_counter.sv
// tb_ascii_bcd_counter
//   Directed bench for ascii_bcd_counter. A 2-digit and a 3-digit instance
//   share clock and reset; each scenario task drives its stimulus and checks
//   results against hand-computed ASCII values.

module tb_ascii_bcd_counter;

  logic        clock;
  logic        reset;

  logic        load2, enable2, up2, wrap2;
  logic [15:0] ascii_in2;
  logic [15:0] counter2;
  logic        done2, wrapped2, error2;

  logic        load3, enable3, up3, wrap3;
  logic [23:0] ascii_in3;
  logic [23:0] counter3;
  logic        done3, wrapped3, error3;

  int checks;
  int errors;

  ascii_bcd_counter #(.DIGITS(2)) dut2 (
    .clock    (clock),
    .reset    (reset),
    .load     (load2),
    .ascii_in (ascii_in2),
    .enable   (enable2),
    .up       (up2),
    .wrap     (wrap2),
    .counter  (counter2),
    .done     (done2),
    .wrapped  (wrapped2),
    .error    (error2)
  );

  ascii_bcd_counter #(.DIGITS(3)) dut3 (
    .clock    (clock),
    .reset    (reset),
    .load     (load3),
    .ascii_in (ascii_in3),
    .enable   (enable3),
    .up       (up3),
    .wrap     (wrap3),
    .counter  (counter3),
    .done     (done3),
    .wrapped  (wrapped3),
    .error    (error3)
  );

  // 10 time-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load2_value(input logic [15:0] value);
    load2     = 1'b1;
    ascii_in2 = value;
    tick();
    load2     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (counter2 !== "00") begin
      errors++;
      $display("[TB] FAIL reset_counter got %s expected 00", counter2);
    end
    checks++;
    if (done2 !== 1'b0 || wrapped2 !== 1'b0 || error2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got d%b w%b e%b expected 000", done2, wrapped2, error2);
    end
    checks++;
    if (counter3 !== "000") begin
      errors++;
      $display("[TB] FAIL reset_counter3 got %s expected 000", counter3);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_count_down_stop();
    up2   = 1'b0;
    wrap2 = 1'b0;
    load2_value("20");
    checks++;
    if (counter2 !== "20" || done2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_20 got %s d%b expected 20 d0", counter2, done2);
    end
    enable2 = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k == 1) begin
        checks++;
        if (counter2 !== "19") begin
          errors++;
          $display("[TB] FAIL down_1 got %s expected 19", counter2);
        end
      end
      if (k == 10) begin
        checks++;
        if (counter2 !== "10") begin
          errors++;
          $display("[TB] FAIL down_10 got %s expected 10", counter2);
        end
      end
      if (k == 19) begin
        checks++;
        if (counter2 !== "01" || done2 !== 1'b0) begin
          errors++;
          $display("[TB] FAIL down_19 got %s d%b expected 01 d0", counter2, done2);
        end
      end
      if (k == 20 || k == 23) begin
        checks++;
        if (counter2 !== "00" || done2 !== 1'b1 || wrapped2 !== 1'b0) begin
          errors++;
          $display("[TB] FAIL down_stop got %s d%b w%b expected 00 d1 w0", counter2, done2, wrapped2);
        end
      end
    end
    // Changing direction and wrap mode must not release DONE.
    up2   = 1'b1;
    wrap2 = 1'b1;
    tick();
    tick();
    checks++;
    if (counter2 !== "00" || done2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_sticky got %s d%b expected 00 d1", counter2, done2);
    end
    enable2 = 1'b0;
    up2     = 1'b0;
    wrap2   = 1'b0;
  endtask

  task automatic test_error_load();
    load2_value("0A");
    checks++;
    if (error2 !== 1'b1 || counter2 !== "00" || done2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_load got %s e%b d%b expected 00 e1 d0", counter2, error2, done2);
    end
    enable2 = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (counter2 !== "00" || error2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_hold got %s e%b expected 00 e1", counter2, error2);
    end
    enable2 = 1'b0;
    load2_value("05");
    checks++;
    if (error2 !== 1'b0 || counter2 !== "05") begin
      errors++;
      $display("[TB] FAIL good_load got %s e%b expected 05 e0", counter2, error2);
    end
    enable2 = 1'b1;
    tick();
    enable2 = 1'b0;
    checks++;
    if (counter2 !== "04") begin
      errors++;
      $display("[TB] FAIL resume got %s expected 04", counter2);
    end
    // Loading the terminal value in stop mode finishes immediately.
    load2_value("00");
    checks++;
    if (done2 !== 1'b1 || counter2 !== "00") begin
      errors++;
      $display("[TB] FAIL load_terminal got %s d%b expected 00 d1", counter2, done2);
    end
  endtask

  task automatic test_up_wrap();
    up2   = 1'b1;
    wrap2 = 1'b1;
    load2_value("98");
    enable2 = 1'b1;
    tick();
    checks++;
    if (counter2 !== "99" || wrapped2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_99 got %s w%b d%b expected 99 w0 d0", counter2, wrapped2, done2);
    end
    tick();
    checks++;
    if (counter2 !== "00" || wrapped2 !== 1'b1 || done2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_wrap got %s w%b d%b expected 00 w1 d0", counter2, wrapped2, done2);
    end
    tick();
    checks++;
    if (counter2 !== "01" || wrapped2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_01 got %s w%b d%b expected 01 w0 d0", counter2, wrapped2, done2);
    end
    enable2 = 1'b0;
    up2     = 1'b0;
    wrap2   = 1'b0;
  endtask

  task automatic test_three_digit();
    up3       = 1'b0;
    wrap3     = 1'b0;
    load3     = 1'b1;
    ascii_in3 = "100";
    tick();
    load3   = 1'b0;
    enable3 = 1'b1;
    tick();
    enable3 = 1'b0;
    checks++;
    if (counter3 !== "099") begin
      errors++;
      $display("[TB] FAIL borrow3 got %s expected 099", counter3);
    end
    up3       = 1'b1;
    load3     = 1'b1;
    ascii_in3 = "199";
    tick();
    load3   = 1'b0;
    enable3 = 1'b1;
    tick();
    enable3 = 1'b0;
    checks++;
    if (counter3 !== "200") begin
      errors++;
      $display("[TB] FAIL carry3 got %s expected 200", counter3);
    end
    up3       = 1'b0;
    wrap3     = 1'b1;
    load3     = 1'b1;
    ascii_in3 = "000";
    tick();
    load3   = 1'b0;
    enable3 = 1'b1;
    tick();
    enable3 = 1'b0;
    checks++;
    if (counter3 !== "999" || wrapped3 !== 1'b1 || done3 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL down_wrap3 got %s w%b d%b expected 999 w1 d0", counter3, wrapped3, done3);
    end
    tick();
    checks++;
    if (wrapped3 !== 1'b0 || counter3 !== "999") begin
      errors++;
      $display("[TB] FAIL wrap_pulse3 got %s w%b expected 999 w0", counter3, wrapped3);
    end
  endtask

  task automatic test_back_to_back();
    up2   = 1'b0;
    wrap2 = 1'b0;
    load2_value("15");
    enable2 = 1'b1;
    tick();
    enable2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (counter2 !== "14" || wrapped2 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_%0d got %s w%b expected 14 w0", k, counter2, wrapped2);
      end
    end
    load2     = 1'b1;
    enable2   = 1'b1;
    ascii_in2 = "42";
    tick();
    load2 = 1'b0;
    checks++;
    if (counter2 !== "42") begin
      errors++;
      $display("[TB] FAIL load_priority got %s expected 42", counter2);
    end
    tick();
    enable2 = 1'b0;
    checks++;
    if (counter2 !== "41") begin
      errors++;
      $display("[TB] FAIL after_priority got %s expected 41", counter2);
    end
  endtask

  task automatic test_async_reset();
    up2   = 1'b0;
    wrap2 = 1'b0;
    load2_value("08");
    enable2 = 1'b1;
    tick();
    enable2 = 1'b0;
    checks++;
    if (counter2 !== "07") begin
      errors++;
      $display("[TB] FAIL pre_reset got %s expected 07", counter2);
    end
    // Force error high first so the reset clearing it is visible.
    load2_value("Z7");
    load2 = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (counter2 !== "00" || done2 !== 1'b0 || wrapped2 !== 1'b0 || error2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got %s d%b w%b e%b expected 00 d0 w0 e0", counter2, done2, wrapped2, error2);
    end
    #2;
    reset   = 1'b1;
    enable2 = 1'b1;
    tick();
    tick();
    tick();
    enable2 = 1'b0;
    checks++;
    if (counter2 !== "00") begin
      errors++;
      $display("[TB] FAIL idle_after_reset got %s expected 00", counter2);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    load2     = 1'b0;
    enable2   = 1'b0;
    up2       = 1'b0;
    wrap2     = 1'b0;
    ascii_in2 = "00";
    load3     = 1'b0;
    enable3   = 1'b0;
    up3       = 1'b0;
    wrap3     = 1'b0;
    ascii_in3 = "000";

    test_reset();
    test_count_down_stop();
    test_error_load();
    test_up_wrap();
    test_three_digit();
    test_back_to_back();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
